// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder.
// The master drives the request; the slave returns status and result.
interface serial_adder_if #(
   parameter int WIDTH = 8
) ();
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout
   );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full adder plus a carry flop.
// Operands are shifted LSB-first; the result lands in one shot on completion.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   serial_adder_if.slave bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] s_sh_q, s_sh_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             c_q, c_d;
   logic             cout_q, cout_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic             fa_sum, fa_cout;
   logic [WIDTH-1:0] s_next;
   logic             last_bit;

   full_adder u_fa (
      .a    (a_sh_q[0]),
      .b    (b_sh_q[0]),
      .cin  (c_q),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   // The new sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at index 0.
   generate
      if (WIDTH == 1) begin : g_s1
         assign s_next = fa_sum;
      end else begin : g_sn
         assign s_next = {fa_sum, s_sh_q[WIDTH-1:1]};
      end
   endgenerate

   assign last_bit = (cnt_q == CW'(WIDTH - 1));

   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      s_sh_d  = s_sh_q;
      c_d     = c_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               a_sh_d  = bus.a;
               b_sh_d  = bus.b;
               c_d     = bus.cin;
               cnt_d   = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            s_sh_d = s_next;
            c_d    = fa_cout;
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            cnt_d  = cnt_q + CW'(1);
            if (last_bit) begin
               sum_d   = s_next;
               cout_d  = fa_cout;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         s_sh_q  <= '0;
         c_q     <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         s_sh_q  <= s_sh_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   assign bus.busy = (state_q == RUN);
   assign bus.done = (state_q == DONE);
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance for the main scenarios
// and a 4-bit instance swept over every operand combination.
module tb_serial_adder;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   serial_adder_if #(.WIDTH(8)) if8 ();
   serial_adder_if #(.WIDTH(4)) if4 ();

   serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
   serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One 8-bit add from idle; inj >= 0 pulses a stray start at that RUN cycle.
   task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic cin, input logic [7:0] es, input logic ec, input int inj);
      int n, nb, stable;
      logic [7:0] prev;
      @(negedge clk);
      if8.start = 1'b1; if8.a = a; if8.b = b; if8.cin = cin;
      prev = if8.sum;
      @(negedge clk);
      if8.start = 1'b0; if8.a = ~a; if8.b = a ^ b; if8.cin = ~cin;
      n = 0; nb = 0; stable = 1;
      while (!if8.done && n < 20) begin
         if (if8.busy) nb++;
         if (if8.sum !== prev) stable = 0;
         if (n == inj) begin
            if8.start = 1'b1; if8.a = 8'hAA; if8.b = 8'h55;
         end else begin
            if8.start = 1'b0;
         end
         n++;
         @(negedge clk);
      end
      if8.start = 1'b0;
      chk({tag, " latency"}, n, 8);
      chk({tag, " busy_cycles"}, nb, 8);
      chk({tag, " done"}, if8.done, 1);
      chk({tag, " sum"}, if8.sum, es);
      chk({tag, " cout"}, if8.cout, ec);
      chk({tag, " stable"}, stable, 1);
      @(negedge clk);
      chk({tag, " done_once"}, {if8.done, if8.busy}, 2'b00);
   endtask

   logic [7:0] bb_a [4] = '{8'h12, 8'h80, 8'hC3, 8'h7F};
   logic [7:0] bb_b [4] = '{8'h34, 8'h80, 8'h3D, 8'h01};
   logic       bb_c [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
   logic [7:0] bb_s [4] = '{8'h46, 8'h01, 8'h00, 8'h81};
   logic       bb_o [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

   initial begin
      int n, stable, ndone;
      logic [7:0] prev;
      if8.start = 0; if8.a = 0; if8.b = 0; if8.cin = 0;
      if4.start = 0; if4.a = 0; if4.b = 0; if4.cin = 0;
      if8.a = 8'hFF; if8.b = 8'hFF; if8.cin = 1'b1; if8.start = 1'b1;
      repeat (3) @(negedge clk);
      // reset held while start is high: nothing may begin
      chk("rst busy", if8.busy, 0);
      chk("rst done", if8.done, 0);
      chk("rst sum", if8.sum, 0);
      chk("rst cout", if8.cout, 0);
      chk("rst w4", {if4.busy, if4.done, if4.cout, if4.sum}, 0);
      if8.start = 1'b0;
      rst_n = 1'b1;

      op8("t1", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, -1);
      op8("t2a", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, -1);
      op8("t2b", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, -1);
      op8("t3", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 3);

      // back-to-back with start held high
      @(negedge clk);
      if8.start = 1'b1; if8.a = bb_a[0]; if8.b = bb_b[0]; if8.cin = bb_c[0];
      prev = if8.sum;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (k < 3) begin
            if8.a = bb_a[k+1]; if8.b = bb_b[k+1]; if8.cin = bb_c[k+1];
         end else begin
            if8.start = 1'b0;
         end
         n = 0; stable = 1;
         while (!if8.done && n < 20) begin
            if (if8.sum !== prev) stable = 0;
            n++;
            @(negedge clk);
         end
         chk($sformatf("t4.%0d period", k), n, 8);
         chk($sformatf("t4.%0d sum", k), if8.sum, bb_s[k]);
         chk($sformatf("t4.%0d cout", k), if8.cout, bb_o[k]);
         chk($sformatf("t4.%0d stable", k), stable, 1);
         prev = if8.sum;
      end
      @(negedge clk);
      chk("t4 idle", {if8.busy, if8.done}, 2'b00);

      // reset in the middle of RUN
      @(negedge clk);
      if8.start = 1'b1; if8.a = 8'hF0; if8.b = 8'h0F; if8.cin = 1'b1;
      @(negedge clk);
      if8.start = 1'b0;
      repeat (4) @(negedge clk);
      chk("t5 busy_pre", if8.busy, 1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("t5 busy", if8.busy, 0);
      chk("t5 done", if8.done, 0);
      chk("t5 sum", if8.sum, 0);
      chk("t5 cout", if8.cout, 0);
      rst_n = 1'b1;
      ndone = 0;
      repeat (12) begin
         @(negedge clk);
         if (if8.done || if8.busy) ndone++;
      end
      chk("t5 no_done", ndone, 0);
      op8("t5 fresh", 8'h21, 8'h43, 1'b1, 8'h65, 1'b0, -1);

      // exhaustive 4-bit sweep
      for (int v = 0; v < 512; v++) begin
         logic [4:0] exp5;
         @(negedge clk);
         if4.a = v[3:0]; if4.b = v[7:4]; if4.cin = v[8]; if4.start = 1'b1;
         exp5 = {1'b0, v[3:0]} + {1'b0, v[7:4]} + {4'b0, v[8]};
         @(negedge clk);
         if4.start = 1'b0;
         n = 0;
         while (!if4.done && n < 10) begin
            n++;
            @(negedge clk);
         end
         chk($sformatf("t6 lat %0d", v), n, 4);
         chk($sformatf("t6 res %0d", v), {if4.cout, if4.sum}, exp5);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
